// File: rtl/sgn_adder_arb_pkg.sv
// Shared types for the round-robin adder scheduler: FSM state encoding and
// the operation-select codes understood by sgn_adder.
package sgn_adder_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   localparam logic [1:0] CTRL_RR  = 2'b00;
   localparam logic [1:0] CTRL_RI  = 2'b01;
   localparam logic [1:0] CTRL_IR  = 2'b10;
   localparam logic [1:0] CTRL_ILL = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// searching upward from last+1, wrapping modulo N_REQ.
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] last,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] gnt_id
);

   localparam int ID_W = $clog2(N_REQ);

   logic w_found;
   int   w_idx;

   always_comb begin
      gnt     = '0;
      gnt_id  = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         w_idx = (int'(last) + i) % N_REQ;
         if (!w_found && req[w_idx]) begin
            gnt[w_idx] = 1'b1;
            gnt_id     = ID_W'(w_idx);
            w_found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sgn_adder.sv
// Signed adder with operand select: d1+d2, d1+imm or imm+d2, producing a
// DATA_W+1 bit sum that cannot overflow. Illegal select yields zero.
module sgn_adder
   import sgn_adder_arb_pkg::*;
#(
   parameter int DATA_W        = 16,
   parameter int IMM_W         = 6,
   parameter bit SIGN_EXT_TYPE = 1'b0
) (
   input  logic [1:0]        ctrl,
   input  logic [DATA_W-1:0] d1,
   input  logic [DATA_W-1:0] d2,
   input  logic [IMM_W-1:0]  imm,
   output logic [DATA_W:0]   sum
);

   logic                     w_fill;
   logic signed [DATA_W:0]   w_d1x;
   logic signed [DATA_W:0]   w_d2x;
   logic signed [DATA_W:0]   w_immx;
   logic signed [DATA_W:0]   w_a;
   logic signed [DATA_W:0]   w_b;

   // SIGN_EXT_TYPE=0 sign-extends the immediate; 1 zero-extends it.
   assign w_fill = (SIGN_EXT_TYPE == 1'b0) ? imm[IMM_W-1] : 1'b0;
   assign w_d1x  = {d1[DATA_W-1], d1};
   assign w_d2x  = {d2[DATA_W-1], d2};
   assign w_immx = {{(DATA_W + 1 - IMM_W){w_fill}}, imm};

   always_comb begin
      w_a = '0;
      w_b = '0;
      case (ctrl)
         CTRL_RR: begin w_a = w_d1x;  w_b = w_d2x;  end
         CTRL_RI: begin w_a = w_d1x;  w_b = w_immx; end
         CTRL_IR: begin w_a = w_immx; w_b = w_d2x;  end
         default: begin w_a = '0;     w_b = '0;     end
      endcase
   end

   assign sum = w_a + w_b;

endmodule

// File: rtl/sgn_adder_arb.sv
// Round-robin scheduler sharing one sgn_adder among N_REQ requesters:
// accept one op, compute it, hold the tagged response until it is taken.
module sgn_adder_arb
   import sgn_adder_arb_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int DATA_W        = 16,
   parameter int IMM_W         = 6,
   parameter bit SIGN_EXT_TYPE = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [2*N_REQ-1:0]        req_ctrl,
   input  logic [N_REQ*DATA_W-1:0]   req_d1,
   input  logic [N_REQ*DATA_W-1:0]   req_d2,
   input  logic [N_REQ*IMM_W-1:0]    req_imm,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [$clog2(N_REQ)-1:0]  rsp_id,
   output logic [DATA_W:0]           rsp_data,
   output logic                      rsp_err
);

   localparam int ID_W = $clog2(N_REQ);

   arb_state_e        r_state;
   logic [ID_W-1:0]   r_last;
   logic [ID_W-1:0]   r_id;
   logic [1:0]        r_ctrl;
   logic [DATA_W-1:0] r_d1;
   logic [DATA_W-1:0] r_d2;
   logic [IMM_W-1:0]  r_imm;
   logic              r_rsp_valid;
   logic [ID_W-1:0]   r_rsp_id;
   logic [DATA_W:0]   r_rsp_data;
   logic              r_rsp_err;

   logic [N_REQ-1:0]  w_gnt;
   logic [ID_W-1:0]   w_gnt_id;
   logic              w_accept;
   logic [DATA_W:0]   w_sum;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .req    (req_valid),
      .last   (r_last),
      .gnt    (w_gnt),
      .gnt_id (w_gnt_id)
   );

   sgn_adder #(
      .DATA_W        (DATA_W),
      .IMM_W         (IMM_W),
      .SIGN_EXT_TYPE (SIGN_EXT_TYPE)
   ) u_add (
      .ctrl (r_ctrl),
      .d1   (r_d1),
      .d2   (r_d2),
      .imm  (r_imm),
      .sum  (w_sum)
   );

   assign w_accept  = (r_state == IDLE) && (|req_valid);
   assign req_ready = (r_state == IDLE) ? w_gnt : '0;

   // Operand capture needs no reset: it is only consumed after an accept.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_id   <= w_gnt_id;
         r_ctrl <= req_ctrl[2*int'(w_gnt_id) +: 2];
         r_d1   <= req_d1[DATA_W*int'(w_gnt_id) +: DATA_W];
         r_d2   <= req_d2[DATA_W*int'(w_gnt_id) +: DATA_W];
         r_imm  <= req_imm[IMM_W*int'(w_gnt_id) +: IMM_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_last      <= ID_W'(N_REQ - 1);
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_last  <= w_gnt_id;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_rsp_valid <= 1'b1;
               r_rsp_id    <= r_id;
               r_rsp_err   <= (r_ctrl == CTRL_ILL);
               r_rsp_data  <= (r_ctrl == CTRL_ILL) ? '0 : w_sum;
               r_state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_sgn_adder_arb.sv
// Randomised and directed bench for sgn_adder_arb against a transaction-level
// reference model (integer arithmetic, round-robin search, phase counter).
module tb_sgn_adder_arb;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int IW = 6;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [2*N-1:0]  req_ctrl;
   logic [N*DW-1:0] req_d1;
   logic [N*DW-1:0] req_d2;
   logic [N*IW-1:0] req_imm;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [1:0]      rsp_id;
   logic [DW:0]     rsp_data;
   logic            rsp_err;

   logic [1:0]    a_ctrl [N];
   logic [DW-1:0] a_d1   [N];
   logic [DW-1:0] a_d2   [N];
   logic [IW-1:0] a_imm  [N];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_ctrl[2*g +: 2]  = a_ctrl[g];
      assign req_d1[DW*g +: DW]  = a_d1[g];
      assign req_d2[DW*g +: DW]  = a_d2[g];
      assign req_imm[IW*g +: IW] = a_imm[g];
   end

   sgn_adder_arb #(
      .N_REQ(N), .DATA_W(DW), .IMM_W(IW), .SIGN_EXT_TYPE(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_ctrl(req_ctrl), .req_d1(req_d1), .req_d2(req_d2), .req_imm(req_imm),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   // Reference model: 0 = waiting for request, 1 = computing, 2 = response held
   int            m_phase;
   int            m_last;
   int            m_id;
   logic [1:0]    m_ctrl;
   logic [DW-1:0] m_d1, m_d2;
   logic [IW-1:0] m_imm;
   logic [DW:0]   m_data;
   logic          m_err;

   int            n_vec = 0;
   int            n_err = 0;
   int            last_w;
   logic [N-1:0]  seen_ready;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int winner();
      for (int i = 1; i <= N; i++) begin
         int idx;
         idx = (m_last + i) % N;
         if (req_valid[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [DW:0] ref_sum(input logic [1:0] c, input logic [DW-1:0] x1,
                                          input logic [DW-1:0] x2, input logic [IW-1:0] im);
      int s1, s2, si, s;
      s1 = int'($signed(x1));
      s2 = int'($signed(x2));
      si = int'($signed(im));
      case (c)
         2'b00:   s = s1 + s2;
         2'b01:   s = s1 + si;
         2'b10:   s = si + s2;
         default: s = 0;
      endcase
      return s[DW:0];
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_last  = N - 1;
   endtask

   // One clock: check outputs at the falling edge, advance model at the rising edge.
   task automatic step();
      int   w;
      logic hs;
      @(negedge clk);
      w = (m_phase == 0) ? winner() : -1;
      seen_ready = req_ready;
      chk("req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
         chk("rsp_data", 32'(rsp_data), 32'(m_data));
         chk("rsp_id",   32'(rsp_id),   32'(m_id));
         chk("rsp_err",  32'(rsp_err),  32'(m_err));
      end
      hs = (m_phase == 2) && rsp_ready;
      @(posedge clk);
      case (m_phase)
         0: if (w >= 0) begin
               m_ctrl = a_ctrl[w]; m_d1 = a_d1[w]; m_d2 = a_d2[w]; m_imm = a_imm[w];
               m_id = w; m_last = w; m_phase = 1;
            end
         1: begin
               m_data  = ref_sum(m_ctrl, m_d1, m_d2, m_imm);
               m_err   = (m_ctrl == 2'b11);
               m_phase = 2;
            end
         default: if (hs) m_phase = 0;
      endcase
      last_w = w;
      #1;
      if (w >= 0) req_valid[w] = 1'b0;
   endtask

   task automatic issue(input int id, input logic [1:0] c, input logic [DW-1:0] x1,
                        input logic [DW-1:0] x2, input logic [IW-1:0] im);
      a_ctrl[id] = c; a_d1[id] = x1; a_d2[id] = x2; a_imm[id] = im;
      req_valid[id] = 1'b1;
   endtask

   // Issue one op and pin grant, latency and result against hand-computed values.
   task automatic run_op(input int id, input logic [1:0] c, input logic [DW-1:0] x1,
                         input logic [DW-1:0] x2, input logic [IW-1:0] im,
                         input logic [DW:0] lit_data, input logic lit_err);
      int k;
      issue(id, c, x1, x2, im);
      k = 0;
      do begin
         step();
         k++;
      end while (last_w < 0 && k < 40);
      chk("op_grant", 32'(seen_ready), 32'd1 << id);
      step();
      chk("op_latency", 32'(rsp_valid), 32'd1);
      chk("op_data",    32'(rsp_data),  32'(lit_data));
      chk("op_err",     32'(rsp_err),   32'(lit_err));
      chk("op_id",      32'(rsp_id),    32'(id));
   endtask

   task automatic drain();
      int k;
      req_valid = '0;
      rsp_ready = 1'b1;
      k = 0;
      while (m_phase != 0 && k < 20) begin
         step();
         k++;
      end
   endtask

   task automatic first_grant_after_reset(input string nm);
      int k;
      repeat (3) step();
      req_valid = '1;
      k = 0;
      do begin
         step();
         k++;
      end while (last_w < 0 && k < 20);
      chk(nm, 32'(seen_ready), 32'd1);
      drain();
   endtask

   initial begin
      int cnt;
      int k;
      for (int i = 0; i < N; i++) begin
         a_ctrl[i] = '0; a_d1[i] = '0; a_d2[i] = '0; a_imm[i] = '0;
      end
      model_reset();
      last_w = -1;
      seen_ready = '0;

      #2;
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_data",  32'(rsp_data),  32'd0);
      chk("rst_id",    32'(rsp_id),    32'd0);
      chk("rst_err",   32'(rsp_err),   32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rsp_ready = 1'b1;

      run_op(0, 2'b00, 16'h7FFF, 16'h0001, 6'h00, 17'h08000, 1'b0);
      step();
      run_op(2, 2'b01, 16'h0000, 16'h0000, 6'h3F, 17'h1FFFF, 1'b0);
      step();
      run_op(2, 2'b10, 16'h0000, 16'h0010, 6'h20, 17'h1FFF0, 1'b0);
      step();
      run_op(1, 2'b11, 16'h0005, 16'h0005, 6'h00, 17'h00000, 1'b1);
      step();
      run_op(3, 2'b00, 16'h8000, 16'h8000, 6'h00, 17'h10000, 1'b0);
      step();
      drain();

      // Fairness: everyone requests continuously; last grant was 3.
      for (int i = 0; i < N; i++) begin
         a_ctrl[i] = 2'($urandom_range(0, 2));
         a_d1[i] = 16'($urandom); a_d2[i] = 16'($urandom); a_imm[i] = 6'($urandom);
      end
      req_valid = '1;
      cnt = 0;
      k = 0;
      while (cnt < 12 && k < 80) begin
         step();
         k++;
         if (last_w >= 0) begin
            chk("fair_order", 32'(seen_ready), 32'd1 << (cnt % N));
            cnt++;
         end
         req_valid = '1;
      end
      if (cnt != 12) chk("fair_timeout", 32'(cnt), 32'd12);
      drain();

      // Backpressure: response held for 10 cycles while others request.
      rsp_ready = 1'b0;
      run_op(1, 2'b00, 16'h1234, 16'h0100, 6'h00, 17'h01334, 1'b0);
      req_valid = 4'b1101;
      repeat (10) begin
         step();
         chk("bp_hold", 32'(rsp_data), 32'h01334);
      end
      rsp_ready = 1'b1;
      req_valid = '0;
      step();
      chk("bp_release", 32'(rsp_valid), 32'd0);
      drain();

      // Reset while computing.
      issue(2, 2'b00, 16'h0101, 16'h0202, 6'h00);
      k = 0;
      do begin
         step();
         k++;
      end while (last_w < 0 && k < 20);
      req_valid = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_exec_valid", 32'(rsp_valid), 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      first_grant_after_reset("rst_exec_grant");

      // Reset while holding a response.
      rsp_ready = 1'b0;
      run_op(3, 2'b00, 16'h0001, 16'h0002, 6'h00, 17'h00003, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_resp_data",  32'(rsp_data),  32'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      rsp_ready = 1'b1;
      first_grant_after_reset("rst_resp_grant");

      // Randomised traffic with random backpressure and occasional withdrawals.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && ($urandom % 3 == 0)) begin
               a_ctrl[i] = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom_range(0, 2));
               case ($urandom % 4)
                  0: a_d1[i] = 16'h8000;
                  1: a_d1[i] = 16'h7FFF;
                  default: a_d1[i] = 16'($urandom);
               endcase
               case ($urandom % 4)
                  0: a_d2[i] = 16'h8000;
                  1: a_d2[i] = 16'h7FFF;
                  default: a_d2[i] = 16'($urandom);
               endcase
               a_imm[i] = 6'($urandom);
               req_valid[i] = 1'b1;
            end else if (req_valid[i] && ($urandom % 64 == 0)) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom % 4 != 0);
         step();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, n_vec=%0d expected completion", n_vec);
      $fatal(1, "watchdog");
   end

endmodule
